// File: rtl/multicycle_ctrl.sv
// Purpose: main control FSM for a multicycle RV32I datapath (Moore outputs, plus a guard on memory wait cycles).
// Latency: lw 5, jalr 5, sw/R/I/jal/lui/auipc 4, branch 3 cycles, plus memory wait cycles.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while MemReady=0. A nonzero FETCH_WAIT_MAX bounds the wait before HALT.
module multicycle_ctrl #(
    parameter int FETCH_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Carry,
    input  logic       Neg,
    input  logic       Overflow,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    // The counter holds completed wait cycles, so its largest value is FETCH_WAIT_MAX-1.
    localparam int CW = (FETCH_WAIT_MAX > 1) ? $clog2(FETCH_WAIT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_WAIT_MAX - 1);

    state_t        state, state_n;
    logic          run;
    logic [CW-1:0] wait_cnt;
    logic          wait_state;
    logic          timeout;
    logic          br_taken;

    // Decode the ALU operation for register/immediate arithmetic. Only the R form uses funct7b5 to select sub.
    function automatic logic [3:0] exec_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [3:0] a;
        case (f3)
            3'b000:  a = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    assign wait_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout    = (FETCH_WAIT_MAX != 0) && !MemReady && (wait_cnt == CNT_LAST);

    // Branch condition taken from the flags of the rs1-rs2 subtraction.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = (Neg != Overflow);
            3'b101:  br_taken = (Neg == Overflow);
            3'b110:  br_taken = Carry;
            3'b111:  br_taken = !Carry;
            default: br_taken = 1'b0;
        endcase
    end

    // The run flag sets on the first clock edge after reset is released. Until then, every output stays at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run <= 1'b0;
        else        run <= 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_n;
    end

    // Count consecutive MemReady=0 cycles in the memory-wait states. The counter clears on any other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= '0;
        else if (run && wait_state && (FETCH_WAIT_MAX != 0) && !MemReady && !timeout)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Next-state and Moore output decode. Only the memory handshake and branch flags act combinationally.
    always_comb begin
        state_n    = state;
        MemReq     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        PCWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        if (!run) begin
            state_n = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_n = S_DECODE;
                    end else if (timeout) begin
                        state_n = S_HALT;
                    end
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b010;
                    case (op)
                        7'b0000011, 7'b0100011: state_n = S_MEMADR;
                        7'b0110011:             state_n = S_EXECR;
                        7'b0010011:             state_n = S_EXECI;
                        7'b1100011:             state_n = S_BRANCH;
                        7'b1101111:             state_n = S_JAL;
                        7'b1100111:             state_n = S_JALR;
                        7'b0110111, 7'b0010111: state_n = S_UPPER;
                        default:                state_n = S_HALT;
                    endcase
                end
                S_MEMADR: begin
                    // op[5] separates a store (0100011) from a load (0000011).
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = op[5] ? 3'b001 : 3'b000;
                    state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                    if (MemReady)     state_n = S_MEMWB;
                    else if (timeout) state_n = S_HALT;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    state_n   = S_FETCH;
                end
                S_MEMWRITE: begin
                    MemReq   = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    if (MemReady)     state_n = S_FETCH;
                    else if (timeout) state_n = S_HALT;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = exec_alu(funct3, funct7b5, 1'b1);
                    state_n    = S_ALUWB;
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = exec_alu(funct3, funct7b5, 1'b0);
                    state_n    = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    state_n  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        state_n = S_HALT;
                    end else begin
                        PCWrite = br_taken;
                        state_n = S_FETCH;
                    end
                end
                S_JALR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    state_n = S_JAL;
                end
                S_JAL: begin
                    // In the jalr path, ALUOut already holds rs1+imm when this state loads it into the PC.
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                    state_n = S_ALUWB;
                end
                S_UPPER: begin
                    ALUSrcB = 2'b01;
                    ImmSrc  = 3'b100;
                    if (op[5]) begin
                        ALUControl = ALU_PASS;
                    end else begin
                        ALUSrcA    = 2'b01;
                        ALUControl = ALU_ADD;
                    end
                    state_n = S_ALUWB;
                end
                S_HALT: begin
                    Illegal = 1'b1;
                end
                default: state_n = S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. Expected output vectors are queued per cycle and compared with sampled outputs.
// Instance u0 waits forever. Instance u4 uses FETCH_WAIT_MAX=4 to exercise the wait timeout.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, Carry, Neg, Overflow, MemReady;
    wire [19:0] obs0, obs4;

    typedef struct packed {
        logic       mreq, adr, mw, irw, rw, pcw;
        logic [1:0] res, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } ctl_t;

    ctl_t         exp_q[$];
    logic [19:0]  obs_q[$];
    int           total = 0;
    int           bad = 0;
    logic         use4 = 1'b0;

    multicycle_ctrl u0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Carry(Carry), .Neg(Neg), .Overflow(Overflow), .MemReady(MemReady),
        .MemReq(obs0[19]), .AdrSrc(obs0[18]), .MemWrite(obs0[17]), .IRWrite(obs0[16]),
        .RegWrite(obs0[15]), .PCWrite(obs0[14]), .ResultSrc(obs0[13:12]), .ALUSrcA(obs0[11:10]),
        .ALUSrcB(obs0[9:8]), .ImmSrc(obs0[7:5]), .ALUControl(obs0[4:1]), .Illegal(obs0[0])
    );

    multicycle_ctrl #(.FETCH_WAIT_MAX(4)) u4 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Carry(Carry), .Neg(Neg), .Overflow(Overflow), .MemReady(MemReady),
        .MemReq(obs4[19]), .AdrSrc(obs4[18]), .MemWrite(obs4[17]), .IRWrite(obs4[16]),
        .RegWrite(obs4[15]), .PCWrite(obs4[14]), .ResultSrc(obs4[13:12]), .ALUSrcA(obs4[11:10]),
        .ALUSrcB(obs4[9:8]), .ImmSrc(obs4[7:5]), .ALUControl(obs4[4:1]), .Illegal(obs4[0])
    );

    function automatic ctl_t mk(input logic mreq, input logic adr, input logic mw, input logic irw,
                                input logic rw, input logic pcw, input logic [1:0] res,
                                input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] imm,
                                input logic [3:0] alu, input logic ill);
        ctl_t c;
        c = {mreq, adr, mw, irw, rw, pcw, res, sa, sb, imm, alu, ill};
        return c;
    endfunction

    function automatic ctl_t e_fetch(input logic rdy);
        return mk(1'b1, 1'b0, 1'b0, rdy, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0);
    endfunction
    function automatic ctl_t e_dec();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b010, 4'b0000, 1'b0);
    endfunction
    function automatic ctl_t e_aluwb();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    endfunction
    function automatic ctl_t e_halt();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1);
    endfunction
    function automatic ctl_t e_memwrite();
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    endfunction
    function automatic ctl_t e_branch(input logic tk);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tk, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0);
    endfunction

    // Drive MemReady from a per-cycle bit pattern (bit c for cycle c) and collect the selected instance's outputs.
    task automatic run_cycles(input int n, input logic [127:0] rdy);
        for (int c = 0; c < n; c++) begin
            MemReady = rdy[c];
            @(negedge clk);
            obs_q.push_back(use4 ? obs4 : obs0);
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse reset. On return the core is in FETCH with the run flag set, at 1 time unit after a rising edge.
    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ctl_t e;
        reset = 1'b0; MemReady = 1'b0; op = 7'h00; funct3 = 3'b000; funct7b5 = 1'b0;
        Zero = 1'b0; Carry = 1'b0; Neg = 1'b0; Overflow = 1'b0;
        #3;
        total++;
        if (obs0 !== 20'h0) begin bad++; $display("FAIL reset_async got=%h want=%h", obs0, 20'h0); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (obs0 !== 20'h0) begin bad++; $display("FAIL reset_pre_edge got=%h want=%h", obs0, 20'h0); end
        @(posedge clk); #1;
        @(negedge clk);
        e = e_fetch(1'b0);
        total++;
        if (obs0 !== e) begin bad++; $display("FAIL reset_first_fetch got=%h want=%h", obs0, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        ctl_t e; logic [19:0] o;
        op = 7'h33; funct3 = 3'b000; funct7b5 = 1'b0;
        exp_q.push_back(e_fetch(1'b1));
        exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0));
        exp_q.push_back(e_aluwb());
        run_cycles(4, '1);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL add c%0d got=%h want=%h", c, o, e); end
        end
    endtask

    task automatic test_alu();
        ctl_t e; logic [19:0] o;
        logic [6:0] t_op [6];
        logic [2:0] t_f3 [6];
        logic       t_f7 [6];
        logic [3:0] t_alu[6];
        t_op  = '{7'h33, 7'h13, 7'h13, 7'h33, 7'h13, 7'h33};
        t_f3  = '{3'b000, 3'b000, 3'b100, 3'b101, 3'b101, 3'b011};
        t_f7  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t_alu = '{4'b0001, 4'b0000, 4'b0100, 4'b1001, 4'b1000, 4'b0111};
        for (int i = 0; i < 6; i++) begin
            op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
            exp_q.push_back(e_fetch(1'b1));
            exp_q.push_back(e_dec());
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                               (t_op[i] == 7'h33) ? 2'b00 : 2'b01, 3'b000, t_alu[i], 1'b0));
            exp_q.push_back(e_aluwb());
            run_cycles(4, '1);
            for (int c = 0; exp_q.size() != 0; c++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL alu%0d c%0d got=%h want=%h", i, c, o, e); end
            end
        end
    endtask

    task automatic test_lw();
        ctl_t e; logic [19:0] o;
        op = 7'h03; funct3 = 3'b010; funct7b5 = 1'b0;
        exp_q.push_back(e_fetch(1'b1));
        exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0));
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
        exp_q.push_back(e_fetch(1'b0));
        run_cycles(9, 128'h041);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL lw c%0d got=%h want=%h", c, o, e); end
        end
    endtask

    task automatic test_sw();
        ctl_t e; logic [19:0] o;
        op = 7'h23; funct3 = 3'b010;
        exp_q.push_back(e_fetch(1'b0));
        exp_q.push_back(e_fetch(1'b1));
        exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 1'b0));
        exp_q.push_back(e_memwrite());
        exp_q.push_back(e_memwrite());
        exp_q.push_back(e_fetch(1'b1));
        run_cycles(7, 128'h062);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL sw c%0d got=%h want=%h", c, o, e); end
        end
        // The extra fetch above completed, so let the fetched sw drain before the next test.
        run_cycles(4, 128'h8);
        obs_q.delete();
    endtask

    task automatic test_branch();
        ctl_t e; logic [19:0] o;
        logic [2:0] t_f3 [7];
        logic [4:0] t_fl [7];   // {Zero, Carry, Neg, Overflow, taken}
        t_f3 = '{3'b100, 3'b100, 3'b101, 3'b001, 3'b110, 3'b111, 3'b000};
        t_fl = '{5'b00101, 5'b00000, 5'b00111, 5'b10000, 5'b01001, 5'b01000, 5'b10001};
        op = 7'h63; funct7b5 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            funct3 = t_f3[i];
            {Zero, Carry, Neg, Overflow} = t_fl[i][4:1];
            exp_q.push_back(e_fetch(1'b1));
            exp_q.push_back(e_dec());
            exp_q.push_back(e_branch(t_fl[i][0]));
            exp_q.push_back(e_fetch(1'b0));
            run_cycles(4, 128'h1);
            for (int c = 0; exp_q.size() != 0; c++) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
                if (o !== e) begin bad++; $display("FAIL branch%0d c%0d got=%h want=%h", i, c, o, e); end
            end
        end
        Zero = 1'b0; Carry = 1'b0; Neg = 1'b0; Overflow = 1'b0;
    endtask

    task automatic test_jump_upper();
        ctl_t e; logic [19:0] o;
        ctl_t jal_e;
        jal_e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0);
        op = 7'h67; funct3 = 3'b000;
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0));
        exp_q.push_back(jal_e); exp_q.push_back(e_aluwb());
        run_cycles(5, 128'h1);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL jalr c%0d got=%h want=%h", c, o, e); end
        end
        op = 7'h6F;
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(jal_e); exp_q.push_back(e_aluwb());
        op = 7'h37;
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 3'b100, 4'b1010, 1'b0));
        exp_q.push_back(e_aluwb());
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 1'b0));
        exp_q.push_back(e_aluwb());
        op = 7'h6F; run_cycles(4, 128'h1);
        op = 7'h37; run_cycles(4, 128'h1);
        op = 7'h17; run_cycles(4, 128'h1);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL jal_upper c%0d got=%h want=%h", c, o, e); end
        end
    endtask

    task automatic test_halt();
        ctl_t e; logic [19:0] o;
        op = 7'h7F; funct3 = 3'b000;
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        for (int k = 0; k < 100; k++) exp_q.push_back(e_halt());
        run_cycles(102, {32{4'h5}});
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL halt_op c%0d got=%h want=%h", c, o, e); end
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs0 !== 20'h0) begin bad++; $display("FAIL halt_reset got=%h want=%h", obs0, 20'h0); end
        #1; reset = 1'b1;
        @(posedge clk); #1;
        op = 7'h63; funct3 = 3'b010; Zero = 1'b1;
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(e_branch(1'b0));
        exp_q.push_back(e_halt()); exp_q.push_back(e_halt());
        run_cycles(5, 128'h1F);
        pulse_reset();
        exp_q.push_back(e_fetch(1'b0));
        run_cycles(1, 128'h0);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL halt_br c%0d got=%h want=%h", c, o, e); end
        end
        Zero = 1'b0;
    endtask

    task automatic test_wait_timeout();
        ctl_t e; logic [19:0] o;
        pulse_reset();
        use4 = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(e_fetch(1'b0));
        exp_q.push_back(e_halt()); exp_q.push_back(e_halt());
        run_cycles(6, 128'h0);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL wait_halt c%0d got=%h want=%h", c, o, e); end
        end
        pulse_reset();
        op = 7'h33; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(e_fetch(1'b0));
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0));
        exp_q.push_back(e_aluwb());
        for (int k = 0; k < 3; k++) exp_q.push_back(e_fetch(1'b0));
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        run_cycles(12, 128'h408);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL wait_clear c%0d got=%h want=%h", c, o, e); end
        end
        use4 = 1'b0;
        pulse_reset();
    endtask

    task automatic test_memwrite_reset();
        ctl_t e; logic [19:0] o;
        pulse_reset();
        op = 7'h23; funct3 = 3'b010;
        exp_q.push_back(e_fetch(1'b1)); exp_q.push_back(e_dec());
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 1'b0));
        run_cycles(3, 128'h1);
        for (int c = 0; exp_q.size() != 0; c++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL mw_pre c%0d got=%h want=%h", c, o, e); end
        end
        MemReady = 1'b0;
        #2;
        e = e_memwrite();
        total++;
        if (obs0 !== e) begin bad++; $display("FAIL mw_active got=%h want=%h", obs0, e); end
        reset = 1'b0;
        #1;
        total++;
        if (obs0 !== 20'h0) begin bad++; $display("FAIL mw_reset_drop got=%h want=%h", obs0, 20'h0); end
        #1; reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(e_fetch(1'b0));
        run_cycles(1, 128'h0);
        e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
        if (o !== e) begin bad++; $display("FAIL mw_resume got=%h want=%h", o, e); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_lw();
        test_sw();
        test_branch();
        test_jump_upper();
        test_halt();
        test_wait_timeout();
        test_memwrite_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter FETCH_WAIT_MAX, default 0, meaning memory-wait cycles tolerated before Illegal is raised (0 = wait forever).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 op  input  7  Instr[6:0] from the instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 Zero, Carry, Neg, Overflow  input  1 each  ALU flags; Carry = unsigned a<b.
REQ-008 MemReady  input  1  memory completes the current access this cycle.
REQ-009 MemReq  output  1  memory access active.
REQ-010 AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut.
REQ-011 MemWrite, IRWrite, RegWrite, PCWrite  output  1 each  write strobes.
REQ-012 ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A register.
REQ-014 ALUSrcB  output  2  00 = B register, 01 = ImmExt, 10 = constant 4.
REQ-015 ImmSrc  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
REQ-016 ALUControl  output  4  encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 sltu, 1000 srl, 1001 sra, 1010 pass-B.
REQ-017 Illegal  output  1  sticky fault flag.

Function
REQ-018 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, HALT. All strobes not listed for a state are 0; unlisted selects are 00/000.
REQ-019 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. When MemReady=1, also assert IRWrite=1 and PCWrite=1 and go to DECODE; otherwise hold.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add. Next state by op:
  - 0000011 and 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 and 0010111 -> UPPER
  - any other op -> HALT
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=000 for loads and 001 for stores; next is MEMREAD for loads, MEMWRITE for stores.
REQ-022 MEMREAD: MemReq=1, AdrSrc=1. When MemReady=1 go to MEMWB; otherwise hold.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-024 MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1 held until the MemReady=1 cycle -> FETCH.
REQ-025 EXECR / EXECI: ALUSrcA=10, ALUSrcB=00 (EXECR) or 01 (EXECI), ImmSrc=000 -> ALUWB.
  - funct3 000: sub only for EXECR with funct7b5=1, else add.
  - 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - 101: funct7b5 ? sra : srl.
REQ-026 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-027 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then -> FETCH.
  - PCWrite=1 iff taken: beq Zero; bne ~Zero; blt Neg!=Overflow; bge Neg==Overflow; bltu Carry; bgeu ~Carry.
  - funct3 010 or 011 -> HALT with no PCWrite.
REQ-028 JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add -> JAL.
REQ-029 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB.
REQ-030 UPPER: ALUSrcB=01, ImmSrc=100; lui uses pass-B; auipc uses ALUSrcA=01 with add -> ALUWB.
REQ-031 HALT: all strobes 0, Illegal=1; exit only by reset.
REQ-032 SHALL count consecutive MemReady=0 cycles in FETCH/MEMREAD/MEMWRITE; when FETCH_WAIT_MAX≠0 and the count reaches FETCH_WAIT_MAX -> HALT. Count clears on MemReady=1 or on leaving the state.
REQ-033 Latency: lw 5, sw 4, R/I-type 4, branch 3, jal 4, jalr 5, lui/auipc 4 cycles, each plus memory wait cycles.
REQ-034 Outputs SHALL be decoded from the registered state and inputs only; no output depends combinationally on MemReady except IRWrite, PCWrite and the FETCH/MEMREAD/MEMWRITE next-state.

Reset
REQ-035 reset=0 SHALL force FETCH, clear the wait counter and Illegal, and drive all strobes 0 asynchronously; MemReq=1 from the first clk edge after reset rises.
REQ-036 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL drop MemWrite in the same cycle, with no partial register write.

Verification
REQ-037 add x3,x1,x2 with MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; ALUControl=0000.
REQ-038 lw with MemReady=0 for 3 cycles in MEMREAD -> AdrSrc=1 held 4 cycles; RegWrite=1 with ResultSrc=01 exactly once.
REQ-039 blt with Neg=1, Overflow=0 -> PCWrite=1 in BRANCH; with Neg=0, Overflow=0 -> PCWrite=0; total 3 cycles.
REQ-040 jalr -> JALR, JAL (PCWrite=1, ResultSrc=00), ALUWB (RegWrite=1); 5 cycles.
REQ-041 op=1111111, or branch funct3=010 -> HALT, Illegal=1 persists 100 cycles; reset=0 clears it and FETCH resumes.
REQ-042 FETCH_WAIT_MAX=4 with MemReady stuck at 0 -> HALT entered on the 4th wait cycle; reset pulse during MEMWRITE -> MemWrite=0 immediately.
